// File: rtl/patgen_core.sv
// patgen_core: video test-pattern generator that re-times upstream syncs/DE and fills active pixels
module patgen_core #(
    parameter int BOX_SIZE = 64,
    parameter int BOX_STEP = 2
) (
    input  logic        DCLK,
    input  logic        DRST,
    input  logic [1:0]  RESOL,
    input  logic [2:0]  PAT_SEL,
    input  logic [23:0] SOLID_RGB,
    input  logic        HSYNC_X_IN,
    input  logic        VSYNC_X_IN,
    input  logic        PRE_DE,
    output logic        DSP_HSYNC_X,
    output logic        DSP_VSYNC_X,
    output logic        DSP_DE,
    output logic [7:0]  DSP_R,
    output logic [7:0]  DSP_G,
    output logic [7:0]  DSP_B
);
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [23:0] rgb_q, rgb_d, solid_q, solid_d;
    logic [10:0] x_q, x_d, y_q, y_d, bx_q, bx_d, by_q, by_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic [2:0]  pat_q, pat_d;
    logic [1:0]  res_q, res_d;
    logic        frame_start;
    logic [10:0] hact, vact;
    logic [2:0]  bar;
    logic [18:0] gq;
    logic [7:0]  gray;
    logic        grid, in_box;
    logic [23:0] pix;

    function automatic logic [10:0] hact_of(input logic [1:0] r);
        return r == 2'd0 ? 11'd640 : r == 2'd1 ? 11'd800 : r == 2'd2 ? 11'd1024 : 11'd1280;
    endfunction

    function automatic logic [10:0] vact_of(input logic [1:0] r);
        return r == 2'd0 ? 11'd480 : r == 2'd1 ? 11'd600 : r == 2'd2 ? 11'd768 : 11'd1024;
    endfunction

    // Clamp into [0, act-BOX_SIZE], move one step, reverse on reaching a wall; returns {dir, pos}
    function automatic logic [11:0] box_step(input logic [10:0] p, input logic d, input logic [10:0] act);
        logic [10:0] lim, c;
        logic [11:0] n;
        lim = act - 11'(BOX_SIZE);
        c = p > lim ? lim : p;
        n = d ? {1'b0, c} + 12'(BOX_STEP) : {1'b0, c} - 12'(BOX_STEP);
        if (d) return n >= {1'b0, lim} ? {1'b0, lim} : {1'b1, n[10:0]};
        return {1'b0, c} <= 12'(BOX_STEP) ? 12'h800 : {1'b0, n[10:0]};
    endfunction

    // Sync/DE delay, frame-start latching, pixel/line counters and box motion
    always_comb begin
        frame_start = vs_q & ~VSYNC_X_IN;
        hs_d = HSYNC_X_IN;
        vs_d = VSYNC_X_IN;
        de_d = PRE_DE;
        pat_d = frame_start ? PAT_SEL : pat_q;
        res_d = frame_start ? RESOL : res_q;
        solid_d = frame_start ? SOLID_RGB : solid_q;
        {dx_d, bx_d} = frame_start ? box_step(bx_q, dx_q, hact_of(RESOL)) : {dx_q, bx_q};
        {dy_d, by_d} = frame_start ? box_step(by_q, dy_q, vact_of(RESOL)) : {dy_q, by_q};
        x_d = !PRE_DE ? 11'd0 : (de_q && x_q != 11'h7FF) ? x_q + 11'd1 : x_q;
        y_d = frame_start ? 11'd0 : (de_q && !PRE_DE) ? y_q + 11'd1 : y_q;
    end

    // Colour of the pixel registered this cycle: column x_d on line y_q
    always_comb begin
        hact = hact_of(res_q);
        vact = vact_of(res_q);
        bar = 3'd0;
        for (int k = 1; k < 8; k++)
            if (14'(x_d) >= 14'(k) * 14'(hact >> 3)) bar = 3'(k);
        gq = res_q == 2'd0 ? {x_d, 8'd0} / 19'd640 :
             res_q == 2'd1 ? {x_d, 8'd0} / 19'd800 :
             res_q == 2'd2 ? {x_d, 8'd0} / 19'd1024 : {x_d, 8'd0} / 19'd1280;
        gray = gq > 19'd255 ? 8'hFF : gq[7:0];
        grid = x_d[5:0] == 6'd0 || y_q[5:0] == 6'd0 || x_d == hact - 11'd1 || y_q == vact - 11'd1;
        in_box = x_d >= bx_q && {1'b0, x_d} < {1'b0, bx_q} + 12'(BOX_SIZE) &&
                 y_q >= by_q && {1'b0, y_q} < {1'b0, by_q} + 12'(BOX_SIZE);
        pix = 24'h0;
        case (pat_q)
            3'd0: pix = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
            3'd1: pix = {3{gray}};
            3'd2: pix = {24{~(x_d[5] ^ y_q[5])}};
            3'd3: pix = {24{grid}};
            3'd4: pix = in_box ? 24'hFF0000 : 24'h0000FF;
            3'd5: pix = solid_q;
            default: pix = 24'h0;
        endcase
        rgb_d = PRE_DE ? pix : 24'h0;
    end

    // State register, asynchronously cleared by DRST
    always_ff @(posedge DCLK or negedge DRST) begin
        if (!DRST) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            de_q <= 1'b0;
            rgb_q <= 24'h0;
            x_q <= 11'd0;
            y_q <= 11'd0;
            bx_q <= 11'd0;
            by_q <= 11'd0;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
            pat_q <= 3'd0;
            res_q <= 2'd0;
            solid_q <= 24'h0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            rgb_q <= rgb_d;
            x_q <= x_d;
            y_q <= y_d;
            bx_q <= bx_d;
            by_q <= by_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            pat_q <= pat_d;
            res_q <= res_d;
            solid_q <= solid_d;
        end
    end

    assign DSP_HSYNC_X = hs_q;
    assign DSP_VSYNC_X = vs_q;
    assign DSP_DE = de_q;
    assign {DSP_R, DSP_G, DSP_B} = rgb_q;
endmodule

// File: tb/tb_patgen_core.sv
// tb_patgen_core: table vectors, directed corner sequences and random frames against a pixel model
module tb_patgen_core;
    localparam int BOX = 64;
    localparam int STEP = 2;
    localparam logic [23:0] COLS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        DCLK, DRST, HSYNC_X_IN, VSYNC_X_IN, PRE_DE;
    logic [1:0]  RESOL;
    logic [2:0]  PAT_SEL;
    logic [23:0] SOLID_RGB;
    logic        DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE;
    logic [7:0]  DSP_R, DSP_G, DSP_B;

    patgen_core #(.BOX_SIZE(BOX), .BOX_STEP(STEP)) dut (
        .DCLK(DCLK), .DRST(DRST), .RESOL(RESOL), .PAT_SEL(PAT_SEL), .SOLID_RGB(SOLID_RGB),
        .HSYNC_X_IN(HSYNC_X_IN), .VSYNC_X_IN(VSYNC_X_IN), .PRE_DE(PRE_DE),
        .DSP_HSYNC_X(DSP_HSYNC_X), .DSP_VSYNC_X(DSP_VSYNC_X), .DSP_DE(DSP_DE),
        .DSP_R(DSP_R), .DSP_G(DSP_G), .DSP_B(DSP_B)
    );

    initial DCLK = 1'b0;
    always #5 DCLK = ~DCLK;

    typedef struct {
        logic [1:0]  res;
        logic [2:0]  pat;
        int          y;
        int          x;
        logic [23:0] solid;
        logic [23:0] exp;
    } vec_t;

    vec_t        tbl [13];
    int          checks = 0, errors = 0;
    int          m_pat, m_res, m_bx, m_by, m_dx, m_dy, m_y, m_run;
    logic [23:0] m_solid;
    logic        m_vs, m_pde;
    logic [23:0] line_buf [2048];

    function automatic int hact_f(input int r);
        return r == 0 ? 640 : r == 1 ? 800 : r == 2 ? 1024 : 1280;
    endfunction

    function automatic int vact_f(input int r);
        return r == 0 ? 480 : r == 1 ? 600 : r == 2 ? 768 : 1024;
    endfunction

    function automatic logic [23:0] pix(input int x, input int y);
        int hact, vact, v;
        hact = hact_f(m_res);
        vact = vact_f(m_res);
        case (m_pat)
            0: begin
                v = x / (hact / 8);
                return COLS[v > 7 ? 7 : v];
            end
            1: begin
                v = x * 256 / hact;
                return v > 255 ? 24'hFFFFFF : {3{8'(v)}};
            end
            2: return ((x / 32 + y / 32) % 2 == 0) ? 24'hFFFFFF : 24'h0;
            3: return (x % 64 == 0 || y % 64 == 0 || x == hact - 1 || y == vact - 1) ? 24'hFFFFFF : 24'h0;
            4: return (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) ? 24'hFF0000 : 24'h0000FF;
            5: return m_solid;
            default: return 24'h0;
        endcase
    endfunction

    task automatic move(inout int p, inout int d, input int act);
        int lim;
        lim = act - BOX;
        if (p > lim) p = lim;
        p = p + d * STEP;
        if (p >= lim) begin
            p = lim;
            d = -1;
        end else if (p <= 0) begin
            p = 0;
            d = 1;
        end
    endtask

    task automatic chk(input string nm, input logic [26:0] got, input logic [26:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pat = 0; m_res = 0; m_solid = 24'h0;
        m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
        m_y = 0; m_run = 0; m_vs = 1'b1; m_pde = 1'b0;
    endtask

    task automatic cyc(input logic hs, input logic vs, input logic de);
        logic [26:0] exp, got;
        logic fs;
        HSYNC_X_IN = hs;
        VSYNC_X_IN = vs;
        PRE_DE = de;
        exp = {hs, vs, de, de ? pix(m_run, m_y) : 24'h0};
        fs = m_vs && !vs;
        @(posedge DCLK);
        @(negedge DCLK);
        got = {DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE, DSP_R, DSP_G, DSP_B};
        chk($sformatf("pixel x=%0d y=%0d", m_run, m_y), got, exp);
        if (de) begin
            line_buf[m_run] = got[23:0];
            m_run = m_run < 2047 ? m_run + 1 : 2047;
        end else begin
            if (m_pde) m_y++;
            m_run = 0;
        end
        if (fs) begin
            m_y = 0;
            move(m_bx, m_dx, hact_f(int'(RESOL)));
            move(m_by, m_dy, vact_f(int'(RESOL)));
            m_pat = int'(PAT_SEL);
            m_res = int'(RESOL);
            m_solid = SOLID_RGB;
        end
        m_vs = vs;
        m_pde = de;
    endtask

    task automatic frame();
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
    endtask

    task automatic line_start();
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(1, 1, 0);
    endtask

    task automatic line(input int len);
        line_start();
        repeat (len) cyc(1, 1, 1);
        cyc(1, 1, 0);
    endtask

    task automatic do_reset(input string nm);
        DRST = 1'b0;
        #1;
        chk(nm, {DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE, DSP_R, DSP_G, DSP_B}, {3'b110, 24'h0});
        HSYNC_X_IN = 1'b1;
        VSYNC_X_IN = 1'b1;
        PRE_DE = 1'b0;
        repeat (2) @(posedge DCLK);
        @(negedge DCLK);
        DRST = 1'b1;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{2'd0, 3'd0, 0, 79,   24'h0, 24'hFFFFFF};
        tbl[1]  = '{2'd0, 3'd0, 0, 80,   24'h0, 24'hFFFF00};
        tbl[2]  = '{2'd0, 3'd0, 0, 639,  24'h0, 24'h000000};
        tbl[3]  = '{2'd2, 3'd1, 0, 0,    24'h0, 24'h000000};
        tbl[4]  = '{2'd2, 3'd1, 0, 512,  24'h0, 24'h808080};
        tbl[5]  = '{2'd2, 3'd1, 0, 1023, 24'h0, 24'hFFFFFF};
        tbl[6]  = '{2'd3, 3'd2, 0, 0,    24'h0, 24'hFFFFFF};
        tbl[7]  = '{2'd3, 3'd2, 0, 32,   24'h0, 24'h000000};
        tbl[8]  = '{2'd3, 3'd2, 32, 32,  24'h0, 24'hFFFFFF};
        tbl[9]  = '{2'd3, 3'd3, 0, 5,    24'h0, 24'hFFFFFF};
        tbl[10] = '{2'd3, 3'd3, 1, 64,   24'h0, 24'hFFFFFF};
        tbl[11] = '{2'd1, 3'd5, 0, 3,    24'h123456, 24'h123456};
        tbl[12] = '{2'd1, 3'd6, 0, 3,    24'hABCDEF, 24'h000000};

        DRST = 1'b1;
        RESOL = 2'd0;
        PAT_SEL = 3'd0;
        SOLID_RGB = 24'h0;
        HSYNC_X_IN = 1'b1;
        VSYNC_X_IN = 1'b1;
        PRE_DE = 1'b0;
        #2;
        do_reset("reset_state");

        // Before any frame start the reset defaults (bars, 640 wide) apply
        PAT_SEL = 3'd3;
        RESOL = 2'd3;
        line(100);
        chk("prevsync_bar79", 27'(line_buf[79]), 27'h0FFFFFF);
        chk("prevsync_bar80", 27'(line_buf[80]), 27'h0FFFF00);

        foreach (tbl[i]) begin
            PAT_SEL = tbl[i].pat;
            RESOL = tbl[i].res;
            SOLID_RGB = tbl[i].solid;
            frame();
            repeat (tbl[i].y) line(40);
            line(tbl[i].x + 1);
            chk($sformatf("vec%0d pat=%0d x=%0d y=%0d", i, tbl[i].pat, tbl[i].x, tbl[i].y),
                27'(line_buf[tbl[i].x]), 27'(tbl[i].exp));
        end

        // Pattern change mid-line only takes effect at the next frame start
        PAT_SEL = 3'd0;
        RESOL = 2'd0;
        frame();
        line_start();
        repeat (100) cyc(1, 1, 1);
        PAT_SEL = 3'd2;
        repeat (100) cyc(1, 1, 1);
        cyc(1, 1, 0);
        chk("midframe_still_bars", 27'(line_buf[150]), 27'h0FFFF00);
        frame();
        line(40);
        chk("nextframe_checker_32_0", 27'(line_buf[32]), 27'h0000000);
        chk("nextframe_checker_0_0", 27'(line_buf[0]), 27'h0FFFFFF);

        // Overlong DE: X saturates at 2047 instead of wrapping to 0
        frame();
        line(2100);
        chk("x_saturate", 27'(line_buf[2047]), 27'h0000000);

        for (int f = 0; f < 10; f++) begin
            PAT_SEL = 3'($urandom_range(0, 7));
            RESOL = 2'($urandom_range(0, 3));
            SOLID_RGB = 24'($urandom);
            frame();
            for (int l = 0; l < 3; l++) begin
                line($urandom_range(1, 900));
                PAT_SEL = 3'($urandom_range(0, 7));
                RESOL = 2'($urandom_range(0, 3));
                SOLID_RGB = 24'($urandom);
            end
        end

        // Reset asserted mid active line, then bars at the next frame
        PAT_SEL = 3'd0;
        RESOL = 2'd0;
        frame();
        line_start();
        repeat (20) cyc(1, 1, 1);
        #2;
        do_reset("reset_midline");
        frame();
        line(200);
        chk("after_reset_bars", 27'(line_buf[100]), 27'h0FFFF00);

        // Box bounce: 288 frame starts reach the right wall, the 289th moves back
        #2;
        do_reset("reset_before_box");
        PAT_SEL = 3'd4;
        repeat (288) frame();
        repeat (256) line(1);
        line(640);
        chk("box288_x575", 27'(line_buf[575]), 27'h00000FF);
        chk("box288_x576", 27'(line_buf[576]), 27'h0FF0000);
        chk("box288_x639", 27'(line_buf[639]), 27'h0FF0000);
        frame();
        repeat (256) line(1);
        line(640);
        chk("box289_x573", 27'(line_buf[573]), 27'h00000FF);
        chk("box289_x574", 27'(line_buf[574]), 27'h0FF0000);
        chk("box289_x637", 27'(line_buf[637]), 27'h0FF0000);
        chk("box289_x638", 27'(line_buf[638]), 27'h00000FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/patgen_core.md
PATGEN_CORE -- requirements
Module: patgen_core

Interface
REQ-001 SHALL have parameter BOX_SIZE, default 64, meaning moving-box edge length in pixels (power of two, 16..128).
REQ-002 SHALL have parameter BOX_STEP, default 2, meaning moving-box displacement per frame per axis in pixels.
REQ-003 SHALL have ports: DCLK  in  1  pixel clock, all logic on rising edge.
REQ-004 SHALL have ports: DRST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: RESOL  in  2  resolution select, 0=640x480, 1=800x600, 2=1024x768, 3=1280x1024.
REQ-006 SHALL have ports: PAT_SEL  in  3  pattern select.
REQ-007 SHALL have ports: SOLID_RGB  in  24  solid-fill color {R,G,B}.
REQ-008 SHALL have ports: HSYNC_X_IN, VSYNC_X_IN  in  1 each  upstream timing syncs, active-low.
REQ-009 SHALL have ports: PRE_DE  in  1  upstream data enable, one cycle ahead of active pixels.
REQ-010 SHALL have ports: DSP_HSYNC_X, DSP_VSYNC_X  out  1 each  registered syncs.
REQ-011 SHALL have ports: DSP_DE  out  1  registered data enable.
REQ-012 SHALL have ports: DSP_R, DSP_G, DSP_B  out  8 each  pixel color.

Function
REQ-013 SHALL delay HSYNC_X_IN, VSYNC_X_IN, PRE_DE by exactly one DCLK to DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE.
REQ-014 SHALL register RGB in the same cycle as DSP_DE; RGB SHALL be 0 whenever DSP_DE=0.
REQ-015 SHALL keep pixel X counter (11 bit): cleared when PRE_DE=0, incremented each cycle DSP_DE=1; first active pixel is X=0.
REQ-016 SHALL keep line Y counter (11 bit): cleared on VSYNC_X_IN falling edge, incremented on each DSP_DE falling edge.
REQ-017 SHALL derive HACT/VACT from RESOL: 640/480, 800/600, 1024/768, 1280/1024.
REQ-018 SHALL latch PAT_SEL and RESOL-derived constants only on VSYNC_X_IN falling edge (frame start); mid-frame changes SHALL take effect next frame.
REQ-019 PAT_SEL=0 SHALL output 8 vertical bars of width HACT/8, order white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00).
REQ-020 PAT_SEL=1 SHALL output gray ramp R=G=B=(X*256/HACT) truncated to 8 bits, max 255.
REQ-021 PAT_SEL=2 SHALL output 32x32 checkerboard: white when X[5]^Y[5]=0, else black.
REQ-022 PAT_SEL=3 SHALL output white grid lines where X[5:0]=0 or Y[5:0]=0 or X=HACT-1 or Y=VACT-1, black elsewhere.
REQ-023 PAT_SEL=4 SHALL output a red BOX_SIZE square at (BX,BY) on blue background; pixel inside when BX<=X<BX+BOX_SIZE and BY<=Y<BY+BOX_SIZE.
REQ-024 Box position SHALL update once per frame at frame start: BX+=/-BOX_STEP per direction flag DX, same for BY/DY.
REQ-025 Bounce: if next BX would exceed HACT-BOX_SIZE, BX SHALL clamp to HACT-BOX_SIZE and DX invert; if next BX<0, BX=0 and DX invert; same for Y with VACT.
REQ-026 On RESOL change latched at frame start, box SHALL be clamped into new active area before the next update.
REQ-027 PAT_SEL=5 SHALL output SOLID_RGB, sampled at frame start.
REQ-028 PAT_SEL=6,7 SHALL output black.
REQ-029 X counter SHALL saturate at 2047, never wrap, when PRE_DE longer than HACT.

Reset
REQ-030 On DRST=0, asynchronously: DSP_HSYNC_X=1, DSP_VSYNC_X=1, DSP_DE=0, RGB=0, X=Y=0, BX=BY=0, DX=DY=+, latched PAT_SEL=0, latched RESOL=0.
REQ-031 After DRST release, first pattern output SHALL occur after first VSYNC_X_IN falling edge; before that RGB follows latched reset values (pattern 0, 640x480).
REQ-032 Reset asserted mid-line SHALL force outputs to reset values immediately, without waiting for DCLK.

Verification
REQ-033 RESOL=0, PAT_SEL=0: pixel X=79 -> RGB=FFFFFF, X=80 -> FFFF00, X=639 -> 000000; DSP_DE one cycle after PRE_DE.
REQ-034 RESOL=2, PAT_SEL=1: X=0 -> 00, X=512 -> 80, X=1023 -> FF all components.
REQ-035 PAT_SEL=4, RESOL=0: after 288 frames from reset BX=576 and DX reversed; frame 289 BX=574.
REQ-036 PAT_SEL changed 0->2 mid-frame: current frame stays bars; next frame (after VSYNC_X_IN fall) checkerboard, (32,0) -> 000000.
REQ-037 DRST pulled low mid active line -> same instant DSP_DE=0, RGB=0, syncs=1; after release, bars resume at next frame start.
REQ-038 PAT_SEL=2, RESOL=3: (0,0) -> FFFFFF, (32,0) -> 000000, (32,32) -> FFFFFF, DSP_DE=0 cycles -> RGB=0.
